// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared state, opcode and datapath-select codes for the
//           multi-cycle RISC-V controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;

    localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] c_RES_DATA      = 2'b01;
    localparam logic [1:0] c_RES_ALURESULT = 2'b10;

    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_RD1   = 2'b10;

    localparam logic [1:0] c_SRCB_RD2  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module  : alu_decoder
// Brief   : Combinational funct3/funct7 to ALUControl decode for the execute
//           states; flags unsupported funct3 values.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_b5,
    input  logic       i_is_rtype,
    output logic [2:0] o_alu_control,
    output logic       o_illegal
);

    always_comb begin
        o_alu_control = c_ALU_ADD;
        o_illegal     = 1'b0;
        case (i_funct3)
            // funct7[5] selects sub only for register-register ops; addi has no sub form
            3'b000:  o_alu_control = (i_is_rtype && i_funct7_b5) ? c_ALU_SUB : c_ALU_ADD;
            3'b010:  o_alu_control = c_ALU_SLT;
            3'b110:  o_alu_control = c_ALU_OR;
            3'b111:  o_alu_control = c_ALU_AND;
            default: o_illegal     = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_controller.sv
// ============================================================================
// Module  : multi_cycle_controller
// Brief   : Moore-style main FSM of a multi-cycle RISC-V datapath. Define
//           MC_MEM_WAIT_EN to enable the mem_ready handshake and timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_controller
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    state_e     r_state_q;
    state_e     w_state_d;
    logic       w_mem_done;
    logic       w_timeout;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic [2:0] w_dec_alu;
    logic       w_dec_illegal;
    logic       w_unused_funct7;

    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

    alu_decoder u_alu_decoder (
        .i_funct3      (funct3),
        .i_funct7_b5   (funct7[5]),
        .i_is_rtype    (r_state_q == S_EXECR),
        .o_alu_control (w_dec_alu),
        .o_illegal     (w_dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state_q <= S_FETCH;
        else        r_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d   = S_FETCH;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = c_RES_ALUOUT;
        ALUSrcA     = c_SRCA_PC;
        ALUSrcB     = c_SRCB_RD2;
        ALUControl  = c_ALU_ADD;
        ImmSrc      = c_IMM_I;
        illegal_op  = 1'b0;
        case (r_state_q)
            S_FETCH: begin
                ALUSrcB   = c_SRCB_FOUR;
                ResultSrc = c_RES_ALURESULT;
                if (w_mem_done) begin
                    w_pc_write = 1'b1;
                    w_ir_write = 1'b1;
                    w_state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_IMM;
                ImmSrc  = c_IMM_B;
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_state_d = S_MEMADR;
                    c_OP_RTYPE:            w_state_d = S_EXECR;
                    c_OP_ITYPE:            w_state_d = S_EXECI;
                    c_OP_BRANCH:           w_state_d = S_BEQ;
                    c_OP_JAL:              w_state_d = S_JAL;
                    default:               illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = c_SRCA_RD1;
                ALUSrcB   = c_SRCB_IMM;
                ImmSrc    = (op == c_OP_STORE) ? c_IMM_S : c_IMM_I;
                w_state_d = (op == c_OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (w_mem_done)      w_state_d = S_MEMWB;
                else if (!w_timeout) w_state_d = S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc   = c_RES_DATA;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                if (!w_mem_done && !w_timeout) w_state_d = S_MEMWRITE;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA    = c_SRCA_RD1;
                ALUSrcB    = (r_state_q == S_EXECI) ? c_SRCB_IMM : c_SRCB_RD2;
                ALUControl = w_dec_alu;
                illegal_op = w_dec_illegal;
                if (!w_dec_illegal) w_state_d = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = c_SRCA_RD1;
                ALUControl = c_ALU_SUB;
                w_pc_write = Zero;
            end
            S_JAL: begin
                ALUSrcA    = c_SRCA_OLDPC;
                ALUSrcB    = c_SRCB_FOUR;
                ImmSrc     = c_IMM_J;
                w_pc_write = 1'b1;
                w_state_d  = S_ALUWB;
            end
            default: w_state_d = S_FETCH;
        endcase
    end

    // Strobes are masked by reset itself so they drop without waiting for a clock.
    assign PCWrite  = w_pc_write  & reset;
    assign IRWrite  = w_ir_write  & reset;
    assign MemWrite = w_mem_write & reset;
    assign RegWrite = w_reg_write & reset;
    assign state    = r_state_q;

`ifdef MC_MEM_WAIT_EN
    localparam logic [7:0] c_TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_wait_cnt_q;
    logic [7:0] w_wait_cnt_d;
    logic       r_mem_err_q;
    logic       w_mem_err_d;
    logic       w_in_wait;

    assign w_in_wait  = (r_state_q == S_FETCH) || (r_state_q == S_MEMREAD) ||
                        (r_state_q == S_MEMWRITE);
    assign w_mem_done = mem_ready;
    assign w_timeout  = w_in_wait && !mem_ready && (r_wait_cnt_q == c_TIMEOUT_M1);

    always_comb begin
        w_wait_cnt_d = 8'd0;
        w_mem_err_d  = r_mem_err_q | w_timeout;
        if (w_in_wait && !mem_ready && !w_timeout && (w_state_d == r_state_q))
            w_wait_cnt_d = r_wait_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt_q <= 8'd0;
            r_mem_err_q  <= 1'b0;
        end else begin
            r_wait_cnt_q <= w_wait_cnt_d;
            r_mem_err_q  <= w_mem_err_d;
        end
    end

    assign mem_err = r_mem_err_q;
`else
    localparam int c_UNUSED_TIMEOUT = MEM_TIMEOUT;
    logic w_unused_mem_ready;

    assign w_unused_mem_ready = mem_ready;
    assign w_mem_done         = 1'b1;
    assign w_timeout          = 1'b0;
    assign mem_err            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
// ============================================================================
// Module  : tb_multi_cycle_controller
// Brief   : Scoreboard bench for multi_cycle_controller; instruction-level
//           reference model pushes per-cycle expectations, a monitor compares.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multi_cycle_controller;

    localparam int TIMEOUT = 4;
`ifdef MC_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3,
                   ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7,
                   ST_ALUWB = 8, ST_BEQ = 9, ST_JAL = 10;

    typedef logic [22:0] vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op, mem_err;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic [3:0] state;

    vec_t actual;
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic exp_mem_err = 1'b0;

    always #5 clk = ~clk;

    multi_cycle_controller #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal_op(illegal_op),
        .mem_err(mem_err), .state(state)
    );

    assign actual = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                     ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op, mem_err};

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic f3_ok(logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic [2:0] alu_of(logic [2:0] f3, logic sub_ok);
        case (f3)
            3'b000:  return sub_ok ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs for one cycle, straight from the per-state output table.
    function automatic vec_t expect_vec(int st, logic [6:0] o, logic [2:0] f3,
                                        logic f7b5, logic z, logic mr, logic merr);
        logic pcw, adr, mw, irw, rw, ill, done;
        logic [1:0] res, sa, sb;
        logic [2:0] alu, imm;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        res = 0; sa = 0; sb = 0; alu = 0; imm = 0;
        done = WAIT_EN ? mr : 1'b1;
        case (st)
            ST_FETCH:    begin sb = 2; res = 2; pcw = done; irw = done; end
            ST_DECODE:   begin
                sa = 1; sb = 1; imm = 3'b010;
                ill = !(o == OP_LW || o == OP_SW || o == OP_R || o == OP_I ||
                        o == OP_BEQ || o == OP_JAL);
            end
            ST_MEMADR:   begin sa = 2; sb = 1; imm = (o == OP_SW) ? 3'b001 : 3'b000; end
            ST_MEMREAD:  begin adr = 1; end
            ST_MEMWB:    begin res = 1; rw = 1; end
            ST_MEMWRITE: begin adr = 1; mw = 1; end
            ST_EXECR:    begin sa = 2; alu = alu_of(f3, f7b5); ill = !f3_ok(f3); end
            ST_EXECI:    begin sa = 2; sb = 1; alu = alu_of(f3, 1'b0); ill = !f3_ok(f3); end
            ST_ALUWB:    begin rw = 1; end
            ST_BEQ:      begin sa = 2; alu = 3'b001; pcw = z; end
            ST_JAL:      begin sa = 1; sb = 2; imm = 3'b011; pcw = 1; end
            default: ;
        endcase
        return {4'(st), pcw, adr, mw, irw, rw, res, sa, sb, alu, imm, ill, merr};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                vec_t e;
                e = exp_q.pop_front();
                check("cycle_outputs", 32'(actual), 32'(e));
            end
        end
    end

    // One clock cycle in state st: drive inputs, record expectation, advance.
    task automatic cyc(int st, logic mr, logic z);
        mem_ready = mr;
        Zero      = z;
        exp_q.push_back(expect_vec(st, op, funct3, funct7[5], z, mr, exp_mem_err));
        @(posedge clk);
        #1;
    endtask

    task automatic mem_access(int st, int forced, output bit ok);
        int waits;
        if (!WAIT_EN) waits = 0;
        else if (forced >= 0) waits = forced;
        else begin
            int r;
            r = int'($urandom_range(0, 19));
            waits = (r < 12) ? 0 : (r < 19) ? int'($urandom_range(1, TIMEOUT - 1)) : TIMEOUT;
        end
        ok = 1'b1;
        for (int i = 0; i < waits; i++) begin
            cyc(st, 1'b0, rbit());
            if (i + 1 == TIMEOUT) begin
                exp_mem_err = 1'b1;
                ok = 1'b0;
                return;
            end
        end
        cyc(st, WAIT_EN ? 1'b1 : rbit(), rbit());
    endtask

    task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                             int fw, int dw, int zf);
        bit ok;
        op = o; funct3 = f3; funct7 = f7;
        mem_access(ST_FETCH, fw, ok);
        if (!ok) return;
        cyc(ST_DECODE, rbit(), rbit());
        case (o)
            OP_LW: begin
                cyc(ST_MEMADR, rbit(), rbit());
                mem_access(ST_MEMREAD, dw, ok);
                if (ok) cyc(ST_MEMWB, rbit(), rbit());
            end
            OP_SW: begin
                cyc(ST_MEMADR, rbit(), rbit());
                mem_access(ST_MEMWRITE, dw, ok);
            end
            OP_R: begin
                cyc(ST_EXECR, rbit(), rbit());
                if (f3_ok(f3)) cyc(ST_ALUWB, rbit(), rbit());
            end
            OP_I: begin
                cyc(ST_EXECI, rbit(), rbit());
                if (f3_ok(f3)) cyc(ST_ALUWB, rbit(), rbit());
            end
            OP_BEQ: cyc(ST_BEQ, rbit(), (zf < 0) ? rbit() : 1'(zf));
            OP_JAL: begin
                cyc(ST_JAL, rbit(), rbit());
                cyc(ST_ALUWB, rbit(), rbit());
            end
            default: ;
        endcase
    endtask

    task automatic reset_checks(string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_strobes"}, 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
        check({tag, "_illegal_op"}, 32'(illegal_op), 32'd0);
        check({tag, "_mem_err"}, 32'(mem_err), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit ok;
        #3;
        reset_checks("por");
        @(posedge clk); #1;
        reset_checks("por_clocked");
        reset = 1'b1;

        run_instr(OP_R,   3'b000, 7'b0000000, 0, 0, -1);  // add
        run_instr(OP_R,   3'b000, 7'b0100000, 0, 0, -1);  // sub
        run_instr(OP_BEQ, 3'b000, 7'b0000000, 0, 0, 1);
        run_instr(OP_BEQ, 3'b000, 7'b0000000, 0, 0, 0);
        run_instr(OP_LW,  3'b010, 7'b0000000, 0, 3, -1);
        run_instr(7'h7F,  3'b000, 7'b0000000, 0, 0, -1);
        run_instr(OP_I,   3'b001, 7'b0100000, 0, 0, -1);
        run_instr(OP_JAL, 3'b000, 7'b0000000, 1, 0, -1);
        run_instr(OP_SW,  3'b010, 7'b0000000, 0, TIMEOUT, -1);
        run_instr(OP_I,   3'b110, 7'b0100000, 0, 0, -1);

        for (int n = 0; n < 300; n++) begin
            int k;
            logic [6:0] o;
            k = int'($urandom_range(0, 7));
            case (k)
                0: o = OP_LW;
                1: o = OP_SW;
                2: o = OP_R;
                3: o = OP_I;
                4: o = OP_BEQ;
                5: o = OP_JAL;
                default: o = 7'($urandom);
            endcase
            run_instr(o, 3'($urandom), 7'($urandom), -1, -1, -1);
        end

        // Reset arriving asynchronously in the middle of EXECR.
        op = OP_R; funct3 = 3'b000; funct7 = 7'b0000000;
        mem_access(ST_FETCH, 0, ok);
        cyc(ST_DECODE, 1'b1, 1'b0);
        #2;
        check("execr_before_reset", 32'(state), 32'd6);
        reset = 1'b0;
        #1;
        reset_checks("async_reset");
        @(posedge clk); #1;
        reset_checks("held_reset");
        reset = 1'b1;
        exp_mem_err = 1'b0;

        run_instr(OP_R,  3'b111, 7'b0000000, 0, 0, -1);
        run_instr(OP_LW, 3'b010, 7'b0000000, 0, 1, -1);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
